// File: rtl/sig_glitch_filter.sv
// Input conditioner: 2-FF synchroniser plus pulse-length qualifier for the timer edge detector.
// Optional abort counter enabled by SIG_GLITCH_FILTER_GLITCH_CNT_EN.
module sig_glitch_filter #(
   parameter int   FILT_W    = 8,
   parameter logic RST_LEVEL = 1'b0
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_en,
   input  logic [FILT_W-1:0] i_filt_len,
   input  logic              i_sig_async,
`ifdef SIG_GLITCH_FILTER_GLITCH_CNT_EN
   input  logic              i_glitch_clr,
   output logic [7:0]        o_glitch_cnt,
`endif
   output logic              o_sig_filt,
   output logic              o_busy,
   output logic              o_glitch
);

   typedef enum logic {
      ST_STABLE,
      ST_QUAL
   } state_t;

   state_t            state;
   state_t            state_nx;
   logic              sync1;
   logic              sync_q;
   logic [FILT_W-1:0] cnt;
   logic [FILT_W-1:0] cnt_nx;
   logic              filt_nx;
   logic              glitch_nx;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         sync1  <= RST_LEVEL;
         sync_q <= RST_LEVEL;
      end else begin
         sync1  <= i_sig_async;
         sync_q <= sync1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state      <= ST_STABLE;
         cnt        <= '0;
         o_sig_filt <= RST_LEVEL;
         o_busy     <= 1'b0;
         o_glitch   <= 1'b0;
      end else begin
         state      <= state_nx;
         cnt        <= cnt_nx;
         o_sig_filt <= filt_nx;
         o_busy     <= (state_nx == ST_QUAL);
         o_glitch   <= glitch_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      filt_nx   = o_sig_filt;
      glitch_nx = 1'b0;
      if (!i_en) begin
         // Disabling is a silent abort: no glitch report.
         state_nx = ST_STABLE;
         cnt_nx   = '0;
      end else begin
         unique case (state)
            ST_STABLE: begin
               if (sync_q != o_sig_filt) begin
                  if (i_filt_len == '0) begin
                     filt_nx = sync_q;
                  end else begin
                     cnt_nx   = FILT_W'(1);
                     state_nx = ST_QUAL;
                  end
               end
            end
            ST_QUAL: begin
               if (sync_q != o_sig_filt) begin
                  // >= so a length lowered mid-run accepts at once.
                  if (cnt >= i_filt_len) begin
                     filt_nx  = sync_q;
                     cnt_nx   = '0;
                     state_nx = ST_STABLE;
                  end else begin
                     cnt_nx = cnt + FILT_W'(1);
                  end
               end else begin
                  cnt_nx    = '0;
                  state_nx  = ST_STABLE;
                  glitch_nx = 1'b1;
               end
            end
            default: begin
               state_nx = ST_STABLE;
               cnt_nx   = '0;
            end
         endcase
      end
   end

`ifdef SIG_GLITCH_FILTER_GLITCH_CNT_EN
   logic [7:0] gcnt;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         gcnt <= 8'd0;
      end else if (i_glitch_clr) begin
         gcnt <= 8'd0;
      end else if (glitch_nx && (gcnt != 8'hFF)) begin
         gcnt <= gcnt + 8'd1;
      end
   end

   assign o_glitch_cnt = gcnt;
`endif

endmodule

// File: tb/tb_sig_glitch_filter.sv
// Randomised bench for sig_glitch_filter against a run-length reference model.
// Abort-counter checks are built only with SIG_GLITCH_FILTER_GLITCH_CNT_EN.
module tb_sig_glitch_filter;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic       a;
   logic [7:0] len;
   logic       filt;
   logic       busy;
   logic       glitch;
`ifdef SIG_GLITCH_FILTER_GLITCH_CNT_EN
   logic       clr;
   logic [7:0] gcnt;
`endif

   int errors = 0;
   int checks = 0;

   // Reference model: last two input samples, filtered level and the
   // number of consecutive differing synchronised samples seen so far.
   logic m_h1 = 1'b0;
   logic m_h2 = 1'b0;
   logic m_filt = 1'b0;
   logic m_busy = 1'b0;
   logic m_glitch = 1'b0;
   int   m_run = 0;
   int   m_gcnt = 0;

   always #5 clk = ~clk;

   sig_glitch_filter dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_en        (en),
      .i_filt_len  (len),
      .i_sig_async (a),
`ifdef SIG_GLITCH_FILTER_GLITCH_CNT_EN
      .i_glitch_clr(clr),
      .o_glitch_cnt(gcnt),
`endif
      .o_sig_filt  (filt),
      .o_busy      (busy),
      .o_glitch    (glitch)
   );

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic model_step();
      logic s;
      if (rst) begin
         m_h1 = 1'b0; m_h2 = 1'b0; m_filt = 1'b0;
         m_run = 0; m_busy = 1'b0; m_glitch = 1'b0;
         m_gcnt = 0;
         return;
      end
      s = m_h2;
      m_h2 = m_h1;
      m_h1 = a;
      m_glitch = 1'b0;
      if (!en) begin
         m_run = 0;
      end else if (s != m_filt) begin
         m_run++;
         if (m_run > int'(len)) begin
            m_filt = s;
            m_run = 0;
         end
      end else begin
         m_glitch = (m_run > 0);
         m_run = 0;
      end
      m_busy = (m_run > 0);
`ifdef SIG_GLITCH_FILTER_GLITCH_CNT_EN
      if (clr) m_gcnt = 0;
      else if (m_glitch && m_gcnt < 255) m_gcnt++;
`endif
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check("filt", 32'(filt), 32'(m_filt));
      check("busy", 32'(busy), 32'(m_busy));
      check("glitch", 32'(glitch), 32'(m_glitch));
`ifdef SIG_GLITCH_FILTER_GLITCH_CNT_EN
      check("gcnt", 32'(gcnt), 32'(m_gcnt));
`endif
   endtask

   function automatic logic abort_next();
      return en && !rst && (m_h2 == m_filt) && (m_run > 0);
   endfunction

   initial begin
      int lat;
      int bcyc;
      int gp;
      rst = 1'b1; en = 1'b1; a = 1'b1; len = 8'd4;
`ifdef SIG_GLITCH_FILTER_GLITCH_CNT_EN
      clr = 1'b0;
`endif
      repeat (3) tick();
      check("rst_filt", 32'(filt), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_glitch", 32'(glitch), 32'd0);

      rst = 1'b0;
      lat = 0;
      do begin
         tick();
         lat++;
      end while (filt !== 1'b1 && lat < 20);
      check("rise_lat", lat, 7);

      len = 8'd3;
      a = 1'b0;
      repeat (8) tick();
      bcyc = 0; gp = 0;
      a = 1'b1;
      for (int i = 0; i < 11; i++) begin
         if (i == 3) a = 1'b0;
         tick();
         bcyc += int'(busy);
         gp += int'(glitch);
      end
      check("rej_busy", bcyc, 3);
      check("rej_glitch", gp, 1);
      check("rej_filt", 32'(filt), 32'd0);

      len = 8'd0;
      bcyc = 0;
      for (int i = 0; i < 24; i++) begin
         if (i % 4 == 0) a = ~a;
         tick();
         bcyc += int'(busy);
      end
      check("zero_busy", bcyc, 0);

      len = 8'd5;
      a = 1'b0;
      repeat (8) tick();
      a = 1'b1;
      repeat (4) tick();
      en = 1'b0;
      gp = 0;
      repeat (3) begin
         tick();
         gp += int'(glitch);
      end
      check("dis_busy", 32'(busy), 32'd0);
      check("dis_glitch", gp, 0);
      check("dis_filt", 32'(filt), 32'd0);
      en = 1'b1;
      lat = 0;
      do begin
         tick();
         lat++;
      end while (filt !== 1'b1 && lat < 20);
      check("reen_lat", lat, 6);

      for (int seg = 0; seg < 400; seg++) begin
         int hold;
         if ($urandom_range(0, 3) != 0) a = ~a;
         if ($urandom_range(0, 5) == 0) len = 8'($urandom_range(0, 6));
         hold = $urandom_range(1, 9);
         for (int k = 0; k < hold; k++) begin
            en = ($urandom_range(0, 11) != 0);
            rst = ($urandom_range(0, 299) == 0);
            tick();
         end
      end
      rst = 1'b0;
      en = 1'b1;

`ifdef SIG_GLITCH_FILTER_GLITCH_CNT_EN
      begin
         int hit;
         rst = 1'b1;
         tick();
         rst = 1'b0;
         len = 8'd3;
         a = 1'b0;
         repeat (6) tick();
         for (int g = 0; g < 300; g++) begin
            a = 1'b1;
            tick();
            a = 1'b0;
            repeat (5) tick();
         end
         check("gcnt_sat", 32'(gcnt), 32'd255);
         a = 1'b1;
         tick();
         a = 1'b0;
         hit = 0;
         for (int i = 0; i < 10 && hit == 0; i++) begin
            clr = abort_next();
            tick();
            if (clr) begin
               check("gcnt_clr", 32'(gcnt), 32'd0);
               hit = 1;
            end
         end
         clr = 1'b0;
         check("clr_hit", hit, 1);
      end
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sig_glitch_filter.md
# sig_glitch_filter

Input conditioning stage placed directly upstream of the timer's falling-edge detector. It synchronises an asynchronous external signal with a 2-FF synchroniser and suppresses pulses shorter than a programmable length. It then presents a clean, registered level to the edge detector, so spurious pulses never reach the timer's event logic. The filter length comes from an APB register field.

## Interface
- FILT_W, 8, width of filter-length input and internal qualify counter
- RST_LEVEL, 1'b0, value loaded into synchroniser flops and o_sig_filt on reset
- i_clk  input  1  system clock, all logic on rising edge
- i_rst  input  1  synchronous, active-high reset
- i_en  input  1  filter enable; 0 freezes output and aborts qualification
- i_filt_len  input  FILT_W  filter length L; a change must persist L+1 consecutive synchronised samples
- i_sig_async  input  1  asynchronous external signal
- o_sig_filt  output  1  filtered, registered level (feeds edge detector)
- o_busy  output  1  high while a candidate transition is being qualified
- o_glitch  output  1  one-cycle pulse when a candidate transition is aborted

## Operation
- Synchroniser: sync1 <= i_sig_async; sync_q <= sync1. Runs every cycle regardless of i_en.
- FSM states: ST_STABLE (cnt = 0) and ST_QUAL (cnt > 0). Counter cnt is FILT_W bits wide.
- ST_STABLE, sync_q == o_sig_filt: stay.
- ST_STABLE, sync_q != o_sig_filt:
  - If L == 0: o_sig_filt <= sync_q and stay.
  - Otherwise: cnt <= 1 and go to ST_QUAL.
- ST_QUAL, sync_q != o_sig_filt:
  - If cnt >= L: o_sig_filt <= sync_q, cnt <= 0, go to ST_STABLE.
  - Otherwise: cnt <= cnt + 1.
- ST_QUAL, sync_q == o_sig_filt: abort. cnt <= 0, go to ST_STABLE, o_glitch <= 1 for one cycle.
- Compare uses `>=`. If L is lowered mid-qualification below cnt, the transition is accepted on the next differing sample.
- cnt never exceeds L ≤ 2^FILT_W−1, so no wrap is possible.
- i_en = 0:
  - State forced to ST_STABLE, cnt <= 0.
  - o_sig_filt holds; o_glitch stays 0 (disable is not a glitch).
  - On re-enable, evaluation resumes at the next edge from cnt = 0.
- o_busy = (state == ST_QUAL), registered.

## Timing
- Reset values:
  - sync1, sync_q, o_sig_filt = RST_LEVEL.
  - o_busy = 0, o_glitch = 0, cnt = 0, state = ST_STABLE.
- Reset has priority over all other inputs. Reset mid-qualification aborts silently, with no o_glitch pulse.
- Let E0 be the first clock edge that samples a new i_sig_async level, held stable.
  - o_sig_filt changes at edge E0+2+L.
  - L = 0 gives 2-cycle latency.
- A pulse held for fewer than L+1 samples never changes o_sig_filt.
  - o_busy is high for as many cycles as the pulse was sampled differing.
  - o_glitch pulses on the cycle after the returning sample is seen.
- o_glitch is never asserted in the same cycle that o_sig_filt changes.

## Configuration
- Macro: SIG_GLITCH_FILTER_GLITCH_CNT_EN.
- Defined:
  - Adds input i_glitch_clr (1 bit) and output o_glitch_cnt (8 bits).
  - o_glitch_cnt increments on every abort event and saturates at 255.
  - i_glitch_clr clears it to 0 synchronously, with priority over a same-cycle increment.
  - o_glitch_cnt resets to 0.
- Undefined: both ports and the counter are absent; all other behaviour is identical.

## Test plan
- Reset: RST_LEVEL=0, i_sig_async=1 while i_rst is held 3 cycles → o_sig_filt=0, o_busy=0, o_glitch=0. After release with L=4, o_sig_filt rises at E0+6, where E0 is the first edge after reset deassertion.
- Glitch reject: L=3, o_sig_filt=0, i_sig_async high for exactly 3 cycles → o_busy high 3 cycles, one o_glitch pulse, o_sig_filt stays 0.
- Accept both directions: L=3, i_sig_async high for 10 cycles then low → o_sig_filt rises at E0+5 and falls 5 edges after the first low sample. No o_glitch.
- Zero length: L=0, toggle i_sig_async every 4 cycles → o_sig_filt mirrors it with 2-cycle latency, o_busy never asserts.
- Disable mid-qualification: L=5, drive high, drop i_en after 2 qualifying cycles for 3 cycles → o_busy drops, no o_glitch, o_sig_filt=0. After re-enable, o_sig_filt rises 6 edges later.
- Macro on: 300 aborted glitches → o_glitch_cnt=255. Assert i_glitch_clr in the same cycle as an abort → o_glitch_cnt=0 next cycle.
